// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC request path: handshake states,
// rotating-priority rank and the level reported for a spurious acknowledge.
package pic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACK1,
      ACK2
   } state_t;

   localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

   // Distance from the highest-priority level; the 3-bit wrap gives mod 8.
   function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] base);
      return lvl - base;
   endfunction

endpackage

// File: rtl/pic_rot_prio_enc.sv
// Combinational rotating-priority encoder: picks the set request whose level
// comes first in the order base, base+1, ... mod 8.
module pic_rot_prio_enc
   import pic_pkg::*;
(
   input  logic [7:0] req,
   input  logic [2:0] base,
   output logic       valid,
   output logic [2:0] idx
);

   logic [2:0] lvl;

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      idx = 3'd0;
      lvl = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         lvl = base + 3'(k);
         if (req[lvl]) begin
            idx = lvl;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/pic_irr_resolver.sv
// PIC request stage: IRR capture, mask, rotating-priority resolution against
// in-service levels, INT generation and the two-pulse INTA handshake.
module pic_irr_resolver
   import pic_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ir,
   input  logic       ltim,
   input  logic [7:0] imr,
   input  logic [7:0] isr_cur,
   input  logic [2:0] n,
   input  logic [4:0] vec_base,
   input  logic       inta_n,
   output logic       int_out,
   output logic [7:0] isr_set,
   output logic [7:0] data_out,
   output logic       data_en,
   output logic       ack_done
);

   state_t     state;
   logic [7:0] ir_q;
   logic [7:0] irr;
   logic [7:0] irr_next;
   logic [7:0] cand;
   logic [7:0] clr;
   logic [2:0] sel;
   logic [2:0] win_idx;
   logic [2:0] isr_idx;
   logic       cand_valid;
   logic       isr_valid;
   logic       win_ok;
   logic       inta_q;
   logic       inta_fall;
   logic       inta_rise;

   assign inta_fall = inta_q & ~inta_n;
   assign inta_rise = ~inta_q & inta_n;
   assign cand      = irr & ~imr;

   pic_rot_prio_enc u_cand_enc (
      .req   (cand),
      .base  (n),
      .valid (cand_valid),
      .idx   (win_idx)
   );

   pic_rot_prio_enc u_isr_enc (
      .req   (isr_cur),
      .base  (n),
      .valid (isr_valid),
      .idx   (isr_idx)
   );

   // A winner only counts if it outranks everything already in service.
   assign win_ok = cand_valid & (~isr_valid | (rank(win_idx, n) < rank(isr_idx, n)));
   assign clr    = (state == IDLE && inta_fall && win_ok) ? (8'h01 << win_idx) : 8'h00;

   // The acknowledge clear is applied last so it beats a same-cycle edge.
   always_comb begin
      irr_next = 8'h00;
      if (ltim) begin
         irr_next = ir_q & ~clr;
      end else begin
         irr_next = (irr | (ir & ~ir_q)) & ~clr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q   <= 8'h00;
         irr    <= 8'h00;
         inta_q <= 1'b1;
      end else begin
         ir_q   <= ir;
         irr    <= irr_next;
         inta_q <= inta_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= SPURIOUS_LEVEL;
         int_out  <= 1'b0;
         isr_set  <= 8'h00;
         data_out <= 8'h00;
         data_en  <= 1'b0;
         ack_done <= 1'b0;
      end else begin
         isr_set  <= 8'h00;
         ack_done <= 1'b0;
         case (state)
            IDLE: begin
               int_out  <= win_ok;
               data_en  <= 1'b0;
               data_out <= 8'h00;
               if (inta_fall) begin
                  state   <= ACK1;
                  int_out <= 1'b0;
                  if (win_ok) begin
                     sel     <= win_idx;
                     isr_set <= 8'h01 << win_idx;
                  end else begin
                     sel <= SPURIOUS_LEVEL;
                  end
               end
            end
            // A falling edge here implies inta_n has already returned high.
            ACK1: begin
               int_out <= 1'b0;
               if (inta_fall) begin
                  state    <= ACK2;
                  data_en  <= 1'b1;
                  data_out <= {vec_base, sel};
               end
            end
            ACK2: begin
               int_out  <= 1'b0;
               data_out <= {vec_base, sel};
               if (inta_rise) begin
                  state    <= IDLE;
                  data_en  <= 1'b0;
                  data_out <= 8'h00;
                  ack_done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pic_irr_resolver.sv
// Directed bench for pic_irr_resolver: hand-computed vectors checked with
// immediate assertions after each clock edge.
module tb_pic_irr_resolver;

   logic       clk;
   logic       rst_n;
   logic [7:0] ir;
   logic       ltim;
   logic [7:0] imr;
   logic [7:0] isr_cur;
   logic [2:0] n;
   logic [4:0] vec_base;
   logic       inta_n;
   logic       int_out;
   logic [7:0] isr_set;
   logic [7:0] data_out;
   logic       data_en;
   logic       ack_done;

   int checks = 0;
   int errors = 0;

   pic_irr_resolver dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ir       (ir),
      .ltim     (ltim),
      .imr      (imr),
      .isr_cur  (isr_cur),
      .n        (n),
      .vec_base (vec_base),
      .inta_n   (inta_n),
      .int_out  (int_out),
      .isr_set  (isr_set),
      .data_out (data_out),
      .data_en  (data_en),
      .ack_done (ack_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Full two-pulse acknowledge starting from IDLE with inta_n high.
   task automatic handshake(input string tag, input logic [7:0] exp_isr, input logic [7:0] exp_data);
      inta_n = 1'b0;
      tick();
      check_output({tag, "_isr_set"}, isr_set, exp_isr);
      check_output({tag, "_int_drop"}, {7'd0, int_out}, 8'h00);
      tick();
      check_output({tag, "_isr_set_one_cycle"}, isr_set, 8'h00);
      inta_n = 1'b1;
      tick();
      tick();
      inta_n = 1'b0;
      tick();
      check_output({tag, "_data_en_rise"}, {7'd0, data_en}, 8'h01);
      check_output({tag, "_data_out"}, data_out, exp_data);
      tick();
      check_output({tag, "_data_out_hold"}, data_out, exp_data);
      inta_n = 1'b1;
      tick();
      check_output({tag, "_ack_done"}, {7'd0, ack_done}, 8'h01);
      check_output({tag, "_data_en_fall"}, {7'd0, data_en}, 8'h00);
      tick();
      check_output({tag, "_ack_done_one_cycle"}, {7'd0, ack_done}, 8'h00);
   endtask

   initial begin
      rst_n    = 1'b0;
      ir       = 8'h00;
      ltim     = 1'b0;
      imr      = 8'h00;
      isr_cur  = 8'h00;
      n        = 3'd0;
      vec_base = 5'h08;
      inta_n   = 1'b1;
      #2;
      check_output("rst_int_out", {7'd0, int_out}, 8'h00);
      check_output("rst_isr_set", isr_set, 8'h00);
      check_output("rst_data_out", data_out, 8'h00);
      check_output("rst_data_en", {7'd0, data_en}, 8'h00);
      check_output("rst_ack_done", {7'd0, ack_done}, 8'h00);
      check_output("rst_irr", dut.irr, 8'h00);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] edge-mode request on ir[3], n=0");
      ir = 8'h08;
      tick();
      check_output("t1_int_latency", {7'd0, int_out}, 8'h00);
      tick();
      check_output("t1_int_rise", {7'd0, int_out}, 8'h01);
      ir = 8'h00;
      handshake("t1", 8'h08, 8'h43);
      check_output("t1_int_after", {7'd0, int_out}, 8'h00);

      $display("[TB] simultaneous ir[2] and ir[5], n=4");
      n  = 3'd4;
      ir = 8'h24;
      tick();
      tick();
      check_output("t2_int_rise", {7'd0, int_out}, 8'h01);
      handshake("t2a", 8'h20, 8'h45);
      check_output("t2_irr_pending", dut.irr, 8'h04);
      check_output("t2_int_pending", {7'd0, int_out}, 8'h01);
      handshake("t2b", 8'h04, 8'h42);
      ir = 8'h00;
      n  = 3'd0;
      tick();

      $display("[TB] in-service block with isr_cur=02, ir[4]");
      isr_cur = 8'h02;
      ir      = 8'h10;
      tick();
      tick();
      tick();
      check_output("t3_blocked", {7'd0, int_out}, 8'h00);
      isr_cur = 8'h00;
      tick();
      check_output("t3_unblocked", {7'd0, int_out}, 8'h01);
      handshake("t3", 8'h10, 8'h44);
      ir = 8'h00;
      tick();

      $display("[TB] masked request imr=08, ir[3]");
      imr = 8'h08;
      ir  = 8'h08;
      tick();
      tick();
      tick();
      check_output("t4_masked", {7'd0, int_out}, 8'h00);
      imr = 8'h00;
      tick();
      check_output("t4_unmasked", {7'd0, int_out}, 8'h01);
      handshake("t4", 8'h08, 8'h43);
      ir = 8'h00;
      tick();

      $display("[TB] level-mode request withdrawn before INTA");
      ltim = 1'b1;
      ir   = 8'h01;
      tick();
      tick();
      tick();
      check_output("t5_int_rise", {7'd0, int_out}, 8'h01);
      ir = 8'h00;
      tick();
      tick();
      handshake("t5_spurious", 8'h00, 8'h47);
      ltim = 1'b0;
      tick();

      $display("[TB] reset during second acknowledge");
      ir = 8'h40;
      tick();
      tick();
      check_output("t6_int_rise", {7'd0, int_out}, 8'h01);
      inta_n = 1'b0;
      tick();
      check_output("t6_isr_set", isr_set, 8'h40);
      inta_n = 1'b1;
      ir     = 8'h42;
      tick();
      tick();
      check_output("t6_irr_latched", dut.irr, 8'h02);
      inta_n = 1'b0;
      tick();
      check_output("t6_data_en", {7'd0, data_en}, 8'h01);
      check_output("t6_data_out", data_out, 8'h46);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("t6_rst_data_en", {7'd0, data_en}, 8'h00);
      check_output("t6_rst_data_out", data_out, 8'h00);
      check_output("t6_rst_irr", dut.irr, 8'h00);
      check_output("t6_rst_int", {7'd0, int_out}, 8'h00);
      ir     = 8'h00;
      inta_n = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      check_output("t6_quiet_after_reset", {7'd0, int_out}, 8'h00);
      ir = 8'h02;
      tick();
      tick();
      check_output("t6_new_edge", {7'd0, int_out}, 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
